// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin result scanner: scan states, default scan
// length and the layout of the 3-word summary record.
package bitcoin_pkg;

  localparam int DEFAULT_NUM_NONCES = 16;

  localparam logic [15:0] OFS_BEST_NONCE = 16'd0;
  localparam logic [15:0] OFS_BEST_HASH  = 16'd1;
  localparam logic [15:0] OFS_HIT_MASK   = 16'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } scan_state_e;

  function automatic logic [15:0] summary_offset(input logic [1:0] sel);
    logic [15:0] ofs;
    case (sel)
      2'd0:    ofs = OFS_BEST_NONCE;
      2'd1:    ofs = OFS_BEST_HASH;
      default: ofs = OFS_HIT_MASK;
    endcase
    return ofs;
  endfunction

  function automatic logic [31:0] summary_word(input logic [1:0]  sel,
                                               input logic [3:0]  best_nonce,
                                               input logic [31:0] best_hash,
                                               input logic [15:0] hit_mask);
    logic [31:0] word;
    case (sel)
      2'd0:    word = {28'b0, best_nonce};
      2'd1:    word = best_hash;
      default: word = {16'b0, hit_mask};
    endcase
    return word;
  endfunction

endpackage

// File: rtl/bitcoin_result_scan_if.sv
// Shared single-port memory bus: the scanner is the master, the memory the slave.
interface bitcoin_result_scan_if;

  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/scan_cmp.sv
// Per-word compare unit: tracks the smallest hash seen (lowest index wins ties)
// and a bitmask of words strictly below the target.
module scan_cmp
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = DEFAULT_NUM_NONCES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [31:0] word_i,
  input  logic [3:0]  index_i,
  input  logic [31:0] target_i,
  output logic [31:0] best_hash_o,
  output logic [3:0]  best_nonce_o,
  output logic [15:0] hit_mask_o
);

  logic [31:0] best_hash_q;
  logic [3:0]  best_nonce_q;
  logic [15:0] hit_mask_q;
  logic [15:0] hit_mask_d;
  logic [15:0] hit_set;
  logic        is_hit;
  logic        is_better;

  assign is_hit    = valid_i && (word_i < target_i);
  assign is_better = valid_i && (word_i < best_hash_q);

  // Mask bits beyond the scan length are never set.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_hit
      if (gi < NUM_NONCES) begin : g_used
        assign hit_set[gi] = is_hit && (index_i == 4'(gi));
      end else begin : g_unused
        assign hit_set[gi] = 1'b0;
      end
    end
  endgenerate

  assign hit_mask_d = hit_mask_q | hit_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      best_hash_q  <= '0;
      best_nonce_q <= '0;
      hit_mask_q   <= '0;
    end else if (clear_i) begin
      best_hash_q  <= 32'hFFFF_FFFF;
      best_nonce_q <= '0;
      hit_mask_q   <= '0;
    end else begin
      hit_mask_q <= hit_mask_d;
      if (is_better) begin
        best_hash_q  <= word_i;
        best_nonce_q <= index_i;
      end
    end
  end

  assign best_hash_o  = best_hash_q;
  assign best_nonce_o = best_nonce_q;
  assign hit_mask_o   = hit_mask_q;

endmodule

// File: rtl/bitcoin_result_scan.sv
// Scans NUM_NONCES consecutive hash words from memory, finds the smallest one and
// the hits below target, then writes a 3-word summary back and pulses done.
module bitcoin_result_scan
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = DEFAULT_NUM_NONCES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [3:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_NONCES - 1);

  scan_state_e state_q;
  logic [15:0] result_addr_q;
  logic [31:0] target_q;
  logic [3:0]  cnt_q;
  logic        iss_v_q;
  logic        rd_v_q;
  logic [3:0]  rd_idx_q;
  logic [1:0]  wr_sel_q;
  logic        done_q;
  logic        found_q;
  logic [3:0]  best_nonce_q;
  logic [31:0] best_hash_q;
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        scan_clear;
  logic        last_sample;
  logic [31:0] cmp_best_hash;
  logic [3:0]  cmp_best_nonce;
  logic [15:0] cmp_hit_mask;

  assign scan_clear  = (state_q == S_IDLE) && start;
  assign last_sample = rd_v_q && (rd_idx_q == LAST_IDX);

  // Two-stage valid/index pipeline lines each sampled word up with its nonce.
  scan_cmp #(
    .NUM_NONCES (NUM_NONCES)
  ) u_cmp (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (scan_clear),
    .valid_i      (rd_v_q),
    .word_i       (mem_read_data),
    .index_i      (rd_idx_q),
    .target_i     (target_q),
    .best_hash_o  (cmp_best_hash),
    .best_nonce_o (cmp_best_nonce),
    .hit_mask_o   (cmp_hit_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      result_addr_q <= '0;
      target_q      <= '0;
      cnt_q         <= '0;
      iss_v_q       <= 1'b0;
      rd_v_q        <= 1'b0;
      rd_idx_q      <= '0;
      wr_sel_q      <= '0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      best_nonce_q  <= '0;
      best_hash_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      rd_v_q   <= iss_v_q;
      rd_idx_q <= cnt_q;
      case (state_q)
        S_IDLE: begin
          done_q   <= 1'b0;
          mem_we_q <= 1'b0;
          iss_v_q  <= 1'b0;
          if (start) begin
            result_addr_q <= result_addr;
            target_q      <= target;
            mem_addr_q    <= hash_addr;
            cnt_q         <= '0;
            iss_v_q       <= 1'b1;
            state_q       <= S_READ;
          end
        end
        S_READ: begin
          if (cnt_q == LAST_IDX) begin
            iss_v_q <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            cnt_q      <= cnt_q + 4'd1;
            mem_addr_q <= mem_addr_q + 16'd1;
            iss_v_q    <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (last_sample) begin
            wr_sel_q <= '0;
            state_q  <= S_WRITE;
          end
        end
        S_WRITE: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= result_addr_q + summary_offset(wr_sel_q);
          mem_wdata_q <= summary_word(wr_sel_q, cmp_best_nonce, cmp_best_hash, cmp_hit_mask);
          wr_sel_q    <= wr_sel_q + 2'd1;
          if (wr_sel_q == 2'd2) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          mem_we_q     <= 1'b0;
          done_q       <= 1'b1;
          found_q      <= |cmp_hit_mask;
          best_nonce_q <= cmp_best_nonce;
          best_hash_q  <= cmp_best_hash;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done           = done_q;
  assign found          = found_q;
  assign best_nonce     = best_nonce_q;
  assign best_hash      = best_hash_q;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: doc/bitcoin_result_scan.md
BITCOIN_RESULT_SCAN -- requirements
Module: bitcoin_result_scan

Interface
REQ-001 SHALL have parameter NUM_NONCES, default 16, the number of consecutive hash words to scan (range 1..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begins a scan when sampled high in IDLE.
REQ-005 SHALL have port hash_addr, input, 16 bits: base address of the NUM_NONCES hash words (word n belongs to nonce n).
REQ-006 SHALL have port result_addr, input, 16 bits: base address of the 3-word summary to be written.
REQ-007 SHALL have port target, input, 32 bits: hit threshold, unsigned.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port found, output, 1 bit: at least one hit occurred in the last scan.
REQ-010 SHALL have port best_nonce, output, 4 bits: index of the smallest hash word.
REQ-011 SHALL have port best_hash, output, 32 bits: value of the smallest hash word.
REQ-012 SHALL have ports mem_clk (output, 1), mem_we (output, 1), mem_addr (output, 16), mem_write_data (output, 32) and mem_read_data (input, 32): the shared memory port, with mem_clk equal to clk.

Function
REQ-013 SHALL implement the states IDLE, READ, DRAIN, WRITE and DONE.
REQ-014 IDLE: on start, SHALL latch hash_addr, result_addr and target, set mem_addr=hash_addr and mem_we=0, clear the hit mask, set the best value to 32'hFFFFFFFF and best index to 0, then go to READ.
REQ-015 Start SHALL be ignored outside IDLE, and changes to the inputs after latching SHALL have no effect on the scan.
REQ-016 Memory read latency: the word for the mem_addr loaded at edge k SHALL be sampled from mem_read_data at edge k+2.
REQ-017 READ: SHALL increment mem_addr once per cycle until hash_addr+NUM_NONCES-1 is issued, then go to DRAIN, which lasts until the last word is sampled.
REQ-018 For each sampled word n, the block SHALL set hit bit n when word < target (strict, unsigned) and replace the best entry when word < best (strict), so the lower index wins a tie.
REQ-019 Address arithmetic SHALL be 16-bit modulo, so hash_addr=16'hFFF8 wraps to 16'h0000.
REQ-020 WRITE: SHALL drive mem_we=1 for exactly 3 consecutive cycles, writing result_addr+0 = {28'b0, best index}, result_addr+1 = best value and result_addr+2 = {16'b0, hit mask}; unused mask bits SHALL be 0.
REQ-021 DONE: SHALL assert done for one cycle with mem_we=0, update found/best_nonce/best_hash, then return to IDLE.
REQ-022 Latency: done SHALL be high during the cycle after edge NUM_NONCES+5, counting the start-sampling edge as edge 0 (edge 21 for the default).
REQ-023 found, best_nonce and best_hash SHALL hold their values until the next DONE or reset.

Reset
REQ-024 While reset is high at a clock edge, the block SHALL enter IDLE and set done=0, found=0, best_nonce=0, best_hash=0, mem_we=0, mem_addr=0 and mem_write_data=0.
REQ-025 Reset during READ, DRAIN or WRITE SHALL abort the scan with no further writes, and a start in the first cycle after reset SHALL be accepted.

Structure
REQ-026 The scan state enum, NUM_NONCES default and summary word offsets (0, 1, 2) SHALL live in a shared package, bitcoin_pkg, also importable by bitcoin_hash.
REQ-027 The per-word compare and update logic SHALL be one sub-module, scan_cmp, taking word, index and valid, and holding best, index and mask.

Verification
REQ-028 Words n*16+100 (n=0..15) with target=101 -> best_nonce=0, best_hash=100, mask=16'h0001, found=1.
REQ-029 All words 32'h0000_0050 with target=32'h50 -> best_nonce=0 (tie rule), mask=0, found=0, and summary words written as 0, 32'h50, 0.
REQ-030 hash_addr=16'hFFF8 with word 13 = 3 and all others 9 -> reads wrap to 16'h0007, and best_nonce=13, best_hash=3.
REQ-031 Start pulsed again mid-READ, and hash_addr changed after start -> result identical to an undisturbed scan, with done on edge 21.
REQ-032 Reset asserted at edge 19 (during WRITE) -> mem_we=0 on the next cycle, no done pulse, outputs 0, and a new scan completes correctly.
REQ-033 NUM_NONCES=1 with word 32'h0 and target=1 -> done on edge 6, found=1, mask=1.
